// File: rtl/env_vca.sv
// Envelope-controlled amplifier: scales a signed sample by an unsigned gain with an
// 8-cycle shift-add multiplier, plus an optional first-order delta-sigma output.
module env_vca #(
  parameter bit PDM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [7:0] envelope,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] out,
  output logic       overrun,
  output logic       pdm_out
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state, state_nx;
  logic [7:0]  smp_reg;
  logic [7:0]  env_reg;
  logic [2:0]  cnt;
  logic [15:0] prod;
  logic [15:0] addend;
  logic [15:0] prod_sum;

  // One envelope bit per cycle, LSB first: add the sign-extended sample shifted into place.
  always_comb begin
    addend   = 16'd0;
    if (env_reg[cnt])
      addend = {{8{smp_reg[7]}}, smp_reg} << cnt;
    prod_sum = prod + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (sample_valid) state_nx = MUL;
      MUL:  if (cnt == 3'd7)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured on acceptance so input changes mid-multiply cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_reg   <= 8'd0;
      env_reg   <= 8'd0;
      cnt       <= 3'd0;
      prod      <= 16'd0;
      out       <= 8'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            smp_reg <= sample;
            env_reg <= envelope;
            cnt     <= 3'd0;
            prod    <= 16'd0;
          end
        end
        MUL: begin
          prod <= prod_sum;
          cnt  <= cnt + 3'd1;
          if (sample_valid) overrun <= 1'b1;
          if (cnt == 3'd7) begin
            out       <= prod_sum[15:8];
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == MUL);

  generate
    if (PDM_EN) begin : g_pdm
      logic [7:0] level;
      logic [7:0] acc;
      logic [8:0] acc_sum;
      logic       pdm_reg;

      // Offset-binary level so silence maps to a 50% duty bitstream.
      assign level   = out ^ 8'h80;
      assign acc_sum = {1'b0, acc} + {1'b0, level};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc     <= 8'd0;
          pdm_reg <= 1'b0;
        end else begin
          acc     <= acc_sum[7:0];
          pdm_reg <= acc_sum[8];
        end
      end

      assign pdm_out = pdm_reg;
    end else begin : g_no_pdm
      assign pdm_out = 1'b0;
    end
  endgenerate

endmodule
